// File: rtl/dcs_pkg.sv
// rtl/dcs_pkg.sv - shared constants and state encoding for the DCS command deframer
package dcs_pkg;
    localparam int DCS_CH_NUM = 41;
    localparam int CMD_W      = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR    = 2'd1,
        DATA    = 2'd2,
        DISCARD = 2'd3
    } dcs_state_t;
endpackage

// File: rtl/dcs_cmd_fifo.sv
// rtl/dcs_cmd_fifo.sv - single-clock first-word-fall-through command FIFO
module dcs_cmd_fifo
    import dcs_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = CMD_W
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic             o_full
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_rd;
    logic             w_wr;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_rd    = i_pop && !o_empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign w_wr    = i_push && (!o_full || w_rd);
    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
endmodule

// File: rtl/dcs_cmd_deframer.sv
// rtl/dcs_cmd_deframer.sv - byte-stream to {addr,data} command deframer; counters under DCS_DEFRAMER_STATS_EN
module dcs_cmd_deframer
    import dcs_pkg::*;
#(
    parameter int CH_SEL     = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  dcs_rx_clk,
    input  logic                  reset,
    input  logic [7:0]            dcs_rxd,
    input  logic [DCS_CH_NUM-1:0] dcs_rx_dv,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [31:0]           cmd_addr,
    output logic [31:0]           cmd_data,
    output logic                  overflow,
    output logic                  frame_err,
    output logic [15:0]           frame_cnt,
    output logic [15:0]           err_cnt,
    input  logic                  clr_flags
);
    dcs_state_t       r_state;
    dcs_state_t       w_next;
    logic [1:0]       r_bcnt;
    logic [1:0]       w_bcnt_nxt;
    logic [31:0]      r_shift;
    logic [31:0]      r_addr;
    logic [CMD_W-1:0] r_cmd;
    logic             r_push;
    logic             r_armed;
    logic             r_overflow;
    logic             r_frame_err;
    logic             w_dv;
    logic             w_unused_dv;
    logic             w_shift_en;
    logic             w_addr_done;
    logic             w_data_done;
    logic             w_trunc;
    logic             w_drop;
    logic             w_pop;
    logic             w_empty;
    logic             w_full;
    logic [CMD_W-1:0] w_rdata;
    logic [31:0]      w_word;

    assign w_dv        = dcs_rx_dv[CH_SEL];
    assign w_unused_dv = &{1'b0, dcs_rx_dv};
    assign w_word      = {r_shift[23:0], dcs_rxd};
    assign w_pop       = cmd_valid && cmd_ready;
    assign w_drop      = r_push && w_full && !w_pop;

    always_ff @(posedge dcs_rx_clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_bcnt  <= 2'd0;
        end else begin
            r_state <= w_next;
            r_bcnt  <= w_bcnt_nxt;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_bcnt_nxt  = r_bcnt;
        w_shift_en  = 1'b0;
        w_addr_done = 1'b0;
        w_data_done = 1'b0;
        w_trunc     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_dv && r_armed) begin
                    w_next     = ADDR;
                    w_shift_en = 1'b1;
                    w_bcnt_nxt = 2'd1;
                end
            end
            ADDR, DATA: begin
                if (w_dv) begin
                    w_shift_en = 1'b1;
                    w_bcnt_nxt = r_bcnt + 2'd1;
                    if (r_bcnt == 2'd3) begin
                        w_next      = (r_state == ADDR) ? DATA : ADDR;
                        w_addr_done = (r_state == ADDR);
                        w_data_done = (r_state == DATA);
                    end
                end else begin
                    // Only a frame ending on a command boundary is clean.
                    w_trunc    = !((r_state == ADDR) && (r_bcnt == 2'd0));
                    w_next     = IDLE;
                    w_bcnt_nxt = 2'd0;
                end
            end
            DISCARD: begin
                if (!w_dv) w_next = IDLE;
                w_bcnt_nxt = 2'd0;
            end
            default: w_next = IDLE;
        endcase
        if (w_drop) begin
            w_next     = DISCARD;
            w_bcnt_nxt = 2'd0;
            w_trunc    = 1'b0;
        end
    end

    always_ff @(posedge dcs_rx_clk) begin
        if (reset) begin
            r_shift     <= '0;
            r_addr      <= '0;
            r_cmd       <= '0;
            r_push      <= 1'b0;
            r_armed     <= 1'b0;
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            // Bytes seen after reset belong to an abandoned frame until dv drops.
            r_armed <= r_armed || !w_dv;
            if (w_shift_en)  r_shift <= w_word;
            if (w_addr_done) r_addr  <= w_word;
            if (w_data_done) r_cmd   <= {r_addr, w_word};
            r_push      <= w_data_done;
            r_overflow  <= !clr_flags && (r_overflow || w_drop);
            r_frame_err <= !clr_flags && (r_frame_err || w_trunc);
        end
    end

    dcs_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .i_clk   (dcs_rx_clk),
        .i_reset (reset),
        .i_push  (r_push),
        .i_wdata (r_cmd),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign cmd_valid = !w_empty;
    assign cmd_addr  = w_rdata[63:32];
    assign cmd_data  = w_rdata[31:0];
    assign overflow  = r_overflow;
    assign frame_err = r_frame_err;

`ifdef DCS_DEFRAMER_STATS_EN
    logic [15:0] r_frame_cnt;
    logic [15:0] r_err_cnt;
    logic        w_clean_end;

    assign w_clean_end = (r_state == ADDR) && !w_dv && (r_bcnt == 2'd0) && !w_drop;

    always_ff @(posedge dcs_rx_clk) begin
        if (reset || clr_flags) begin
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            if (w_clean_end && (r_frame_cnt != 16'hFFFF))
                r_frame_cnt <= r_frame_cnt + 16'd1;
            if ((w_trunc || w_drop) && (r_err_cnt != 16'hFFFF))
                r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign err_cnt   = r_err_cnt;
`else
    assign frame_cnt = 16'd0;
    assign err_cnt   = 16'd0;
`endif
endmodule

// File: tb/tb_dcs_cmd_deframer.sv
// tb/tb_dcs_cmd_deframer.sv - directed self-checking bench for dcs_cmd_deframer
module tb_dcs_cmd_deframer;
    localparam int CH    = 3;
    localparam int DEPTH = 4;
`ifdef DCS_DEFRAMER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        dcs_rx_clk = 1'b0;
    logic        reset      = 1'b1;
    logic [7:0]  dcs_rxd    = 8'h00;
    logic [40:0] dcs_rx_dv  = '0;
    logic        cmd_valid;
    logic        cmd_ready  = 1'b0;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_data;
    logic        overflow;
    logic        frame_err;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;
    logic        clr_flags  = 1'b0;

    int checks   = 0;
    int failures = 0;

    dcs_cmd_deframer #(.CH_SEL(CH), .FIFO_DEPTH(DEPTH)) dut (
        .dcs_rx_clk (dcs_rx_clk),
        .reset      (reset),
        .dcs_rxd    (dcs_rxd),
        .dcs_rx_dv  (dcs_rx_dv),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt),
        .clr_flags  (clr_flags)
    );

    always #5 dcs_rx_clk = ~dcs_rx_clk;

    task automatic tick();
        @(posedge dcs_rx_clk);
        #1;
    endtask

    task automatic send_byte(input int ch, input logic [7:0] b);
        dcs_rx_dv     = '0;
        dcs_rx_dv[ch] = 1'b1;
        dcs_rxd       = b;
        tick();
    endtask

    task automatic send_word(input int ch, input logic [31:0] w);
        send_byte(ch, w[31:24]);
        send_byte(ch, w[23:16]);
        send_byte(ch, w[15:8]);
        send_byte(ch, w[7:0]);
    endtask

    task automatic end_frame();
        dcs_rx_dv = '0;
        dcs_rxd   = 8'h00;
    endtask

    function automatic logic [31:0] addr_of(input int i);
        return {8'hA0 + 8'(i), 8'h11, 8'h22, 8'h30 + 8'(i)};
    endfunction

    function automatic logic [31:0] data_of(input int i);
        return {8'hC0 + 8'(i), 8'h5A, 8'hA5, 8'h07 + 8'(i)};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_valid", 32'(cmd_valid), 32'd0);
        chk("rst_addr", cmd_addr, 32'd0);
        chk("rst_data", cmd_data, 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        tick();
    endtask

    task automatic test_single();
        cmd_ready = 1'b1;
        send_word(CH, 32'h0000_0010);
        send_word(CH, 32'hDEAD_BEEF);
        end_frame();
        chk("single_valid_lat1", 32'(cmd_valid), 32'd0);
        tick();
        chk("single_valid_lat2", 32'(cmd_valid), 32'd1);
        chk("single_addr", cmd_addr, 32'h0000_0010);
        chk("single_data", cmd_data, 32'hDEAD_BEEF);
        chk("single_frame_cnt", 32'(frame_cnt), STATS ? 32'd1 : 32'd0);
        tick();
        chk("single_valid_one_cycle", 32'(cmd_valid), 32'd0);
        chk("single_frame_err", 32'(frame_err), 32'd0);
        tick();
    endtask

    task automatic test_back_pressure();
        cmd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_word(CH, addr_of(i));
            send_word(CH, data_of(i));
        end
        end_frame();
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("bp_hold_valid", 32'(cmd_valid), 32'd1);
            chk("bp_hold_addr", cmd_addr, addr_of(0));
            chk("bp_hold_data", cmd_data, data_of(0));
            tick();
        end
        cmd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_pop_valid", 32'(cmd_valid), 32'd1);
            chk("bp_pop_addr", cmd_addr, addr_of(i));
            chk("bp_pop_data", cmd_data, data_of(i));
            tick();
        end
        chk("bp_drained", 32'(cmd_valid), 32'd0);
        chk("bp_frame_cnt", 32'(frame_cnt), STATS ? 32'd2 : 32'd0);
    endtask

    task automatic test_truncation();
        send_word(CH, 32'h1234_5678);
        send_byte(CH, 8'h9A);
        send_byte(CH, 8'hBC);
        end_frame();
        tick();
        chk("trunc_frame_err", 32'(frame_err), 32'd1);
        tick();
        chk("trunc_no_push", 32'(cmd_valid), 32'd0);
        chk("trunc_err_cnt", 32'(err_cnt), STATS ? 32'd1 : 32'd0);
        chk("trunc_frame_cnt", 32'(frame_cnt), STATS ? 32'd2 : 32'd0);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("clr_frame_err", 32'(frame_err), 32'd0);
        chk("clr_err_cnt", 32'(err_cnt), 32'd0);
        chk("clr_frame_cnt", 32'(frame_cnt), 32'd0);
    endtask

    task automatic test_overflow();
        cmd_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            send_word(CH, addr_of(i + 4));
            send_word(CH, data_of(i + 4));
        end
        end_frame();
        tick();
        tick();
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_no_frame_err", 32'(frame_err), 32'd0);
        chk("ovf_err_cnt", 32'(err_cnt), STATS ? 32'd1 : 32'd0);
        chk("ovf_frame_cnt", 32'(frame_cnt), 32'd0);
        cmd_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("ovf_kept_valid", 32'(cmd_valid), 32'd1);
            chk("ovf_kept_addr", cmd_addr, addr_of(i + 4));
            chk("ovf_kept_data", cmd_data, data_of(i + 4));
            tick();
        end
        chk("ovf_rest_dropped", 32'(cmd_valid), 32'd0);
        send_word(CH, 32'h0000_0044);
        send_word(CH, 32'h0BAD_F00D);
        end_frame();
        cmd_ready = 1'b0;
        tick();
        chk("ovf_idle_valid", 32'(cmd_valid), 32'd1);
        chk("ovf_idle_addr", cmd_addr, 32'h0000_0044);
        chk("ovf_idle_data", cmd_data, 32'h0BAD_F00D);
        chk("ovf_idle_frame_cnt", 32'(frame_cnt), STATS ? 32'd1 : 32'd0);
        cmd_ready = 1'b1;
        tick();
        chk("ovf_sticky", 32'(overflow), 32'd1);
    endtask

    task automatic test_channel_isolation();
        send_word(CH + 1, 32'h0000_0020);
        send_word(CH + 1, 32'hCAFE_F00D);
        end_frame();
        tick();
        tick();
        chk("iso_valid", 32'(cmd_valid), 32'd0);
        chk("iso_frame_err", 32'(frame_err), 32'd0);
        chk("iso_frame_cnt", 32'(frame_cnt), STATS ? 32'd1 : 32'd0);
    endtask

    task automatic test_reset_mid_frame();
        send_byte(CH, 8'h00);
        send_byte(CH, 8'h00);
        send_byte(CH, 8'h00);
        reset = 1'b1;
        send_byte(CH, 8'h30);
        reset = 1'b0;
        send_word(CH, 32'h1111_2222);
        send_word(CH, 32'h3333_4444);
        end_frame();
        tick();
        tick();
        chk("rmid_no_push", 32'(cmd_valid), 32'd0);
        chk("rmid_frame_err", 32'(frame_err), 32'd0);
        chk("rmid_overflow_cleared", 32'(overflow), 32'd0);
        send_word(CH, 32'h0000_0050);
        send_word(CH, 32'h1357_9BDF);
        end_frame();
        tick();
        chk("rmid_next_valid", 32'(cmd_valid), 32'd1);
        chk("rmid_next_addr", cmd_addr, 32'h0000_0050);
        chk("rmid_next_data", cmd_data, 32'h1357_9BDF);
        chk("rmid_frame_cnt", 32'(frame_cnt), STATS ? 32'd1 : 32'd0);
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_pressure();
        test_truncation();
        test_overflow();
        test_channel_isolation();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
